instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction-fetch stage of the single-cycle/pipelined RV32I core, sitting directly upstream of the instruction ROM. It owns the program counter, drives the ROM word address, captures the combinational ROM output into an IF/ID register with a valid flag, and accepts stall and branch/jump redirect from downstream. Fetches outside the ROM or to misaligned targets halt the stage with a sticky cause flag.

## Interface
- ADDR_W, 5, ROM word-address width (ROM depth = 2^ADDR_W words)
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word-aligned)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, asynchronous assert, active-low
- stall  in  1  decode not ready; hold PC and IF/ID register
- redirect  in  1  taken branch/jump from execute
- redirectTarget  in  32  byte address of the redirect
- romAddress  out  ADDR_W  word address to ROM, = pc[ADDR_W+1:2]
- romData  in  32  ROM readData (combinational, same cycle)
- pc  out  32  current fetch PC
- instrValid  out  1  IF/ID holds a valid instruction
- instr  out  32  captured instruction
- instrPc  out  32  PC of captured instruction
- instrPcPlus4  out  32  instrPc + 4
- misaligned  out  1  sticky: redirect target with [1:0] != 0
- outOfRange  out  1  sticky: fetch PC beyond ROM

## Operation
- States: IDLE, RUN, HALT.
- Reset (rst_n=0, any time, async): state=IDLE, pc=RESET_PC, instrValid=0, instr=32'h0000_0013 (NOP), instrPc=0, instrPcPlus4=4, misaligned=0, outOfRange=0.
- IDLE: first edge after rst_n deasserts -> RUN; no capture, pc unchanged.
- RUN, per edge, priority top-down:
  - redirect=1, redirectTarget[1:0]!=0: -> HALT, misaligned=1, instrValid=0, pc unchanged.
  - redirect=1, aligned: pc<=redirectTarget, instrValid<=0, instr<=NOP (flush); overrides stall.
  - stall=1: pc, instr, instrPc, instrValid all hold.
  - pc[31:ADDR_W+2]!=0: -> HALT, outOfRange=1, instrValid=0.
  - else: instr<=romData, instrPc<=pc, instrPcPlus4<=pc+4, instrValid<=1, pc<=pc+4.
- HALT: all registers frozen except instrValid=0; exit only via reset.
- Arithmetic: pc+4 is 32-bit modulo 2^32; overflow wrap to 0 is not an error by itself (0 is in range).
- romAddress is purely combinational from pc; instrPcPlus4 is registered, not recomputed.

## Timing
- Fetch latency: pc presented at cycle n -> instr/instrPc valid after edge n+1.
- Throughput: one instruction per cycle when stall=0, redirect=0.
- Redirect penalty: one bubble (instrValid=0) cycle; target instruction visible the edge after.
- stall and redirect are sampled only at rising clk; outputs change only at clk edge or asynchronous reset.
- Sticky flags set on the same edge as HALT entry.
- Reset mid-operation: immediate return to reset values, in-flight instruction discarded.

## Structure
- Shared package fetch_pkg: state enum (IDLE/RUN/HALT), NOP constant 32'h0000_0013, PC_STEP=4.
- ROM_BYTES derived locally from ADDR_W.
- Single module; next-PC selection stays inline, no sub-module required. Top-level connects romAddress/romData to the existing ROM instance.

## Test plan
- Reset, release, stall=0, ROM loaded with test program -> after IDLE cycle, instr = 0x00300413, 0x00100493, 0x01000913 on consecutive cycles with instrPc 0x0, 0x4, 0x8, instrValid=1.
- stall=1 for 2 cycles while instrPc=0x4 -> instr stays 0x00100493, pc stays 0x8; stall released -> next instr 0x01000913.
- redirect=1, redirectTarget=0x34 with stall=1 -> next cycle instrValid=0, pc=0x34; following cycle instr=0x01228863, instrPc=0x34, instrPcPlus4=0x38.
- redirect=1, redirectTarget=0x36 -> HALT, misaligned=1, instrValid=0, pc frozen for 5+ cycles.
- ADDR_W=5, redirect to 0x80 -> one bubble, then HALT with outOfRange=1, instrValid=0; misaligned=0.
- From HALT, pulse rst_n low mid-cycle -> outputs asynchronously reset (flags 0, pc=RESET_PC), normal fetch from 0x0 resumes.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the fetch FSM state enum, the NOP encoding and the PC step.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction ROM bus between the fetch stage and the ROM.
// master: drives romAddress, reads romData. slave: the ROM side.
interface instr_fetch_if #(
    parameter int ADDR_W = 5
);

    logic [ADDR_W-1:0] romAddress;
    logic [31:0]       romData;

    modport master (
        output romAddress,
        input  romData
    );

    modport slave (
        input  romAddress,
        output romData
    );

endinterface

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, addresses the ROM, and captures
// the ROM word into the IF/ID register. Ports: clk, rst_n, stall,
// redirect/redirectTarget, rom (ROM bus), pc, instr* (IF/ID outputs),
// misaligned/outOfRange (sticky halt causes).
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int          ADDR_W   = 5,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [31:0]          redirectTarget,
    instr_fetch_if.master        rom,
    output logic [31:0]          pc,
    output logic                 instrValid,
    output logic [31:0]          instr,
    output logic [31:0]          instrPc,
    output logic [31:0]          instrPcPlus4,
    output logic                 misaligned,
    output logic                 outOfRange
);

    localparam logic [31:0] ROM_BYTES = 32'd4 << ADDR_W;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] ipc4_q, ipc4_d;
    logic        mis_q, mis_d;
    logic        oor_q, oor_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= NOP;
            ipc_q   <= 32'd0;
            ipc4_q  <= PC_STEP;
            mis_q   <= 1'b0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            ipc4_q  <= ipc4_d;
            mis_q   <= mis_d;
            oor_q   <= oor_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        ipc4_d  = ipc4_q;
        mis_d   = mis_q;
        oor_d   = oor_q;
        unique case (state_q)
            IDLE: begin
                state_d = RUN;
            end
            RUN: begin
                if (redirect && (redirectTarget[1:0] != 2'b00)) begin
                    state_d = HALT;
                    mis_d   = 1'b1;
                    valid_d = 1'b0;
                end else if (redirect) begin
                    // Flush: the word fetched this cycle is on the wrong path.
                    pc_d    = redirectTarget;
                    valid_d = 1'b0;
                    instr_d = NOP;
                end else if (stall) begin
                    valid_d = valid_q;
                end else if (pc_q >= ROM_BYTES) begin
                    state_d = HALT;
                    oor_d   = 1'b1;
                    valid_d = 1'b0;
                end else begin
                    instr_d = rom.romData;
                    ipc_d   = pc_q;
                    ipc4_d  = pc_q + PC_STEP;
                    valid_d = 1'b1;
                    pc_d    = pc_q + PC_STEP;
                end
            end
            HALT: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rom.romAddress = pc_q[ADDR_W+1:2];
    assign pc             = pc_q;
    assign instrValid     = valid_q;
    assign instr          = instr_q;
    assign instrPc        = ipc_q;
    assign instrPcPlus4   = ipc4_q;
    assign misaligned     = mis_q;
    assign outOfRange     = oor_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch.
// Models a 32-word combinational ROM and checks fetch, stall, redirect and halts.
module tb_instr_fetch;
    import fetch_pkg::*;

    localparam logic [31:0] W0  = 32'h0030_0413;
    localparam logic [31:0] W1  = 32'h0010_0493;
    localparam logic [31:0] W2  = 32'h0100_0913;
    localparam logic [31:0] W13 = 32'h0122_8863;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectTarget;
    logic [31:0] pc;
    logic        instrValid;
    logic [31:0] instr;
    logic [31:0] instrPc;
    logic [31:0] instrPcPlus4;
    logic        misaligned;
    logic        outOfRange;
    logic [31:0] rom [32];

    int n_vec = 0;
    int n_err = 0;

    instr_fetch_if #(.ADDR_W(5)) rom_bus ();

    assign rom_bus.romData = rom[rom_bus.romAddress];

    instr_fetch #(.ADDR_W(5), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect       (redirect),
        .redirectTarget (redirectTarget),
        .rom            (rom_bus),
        .pc             (pc),
        .instrValid     (instrValid),
        .instr          (instr),
        .instrPc        (instrPc),
        .instrPcPlus4   (instrPcPlus4),
        .misaligned     (misaligned),
        .outOfRange     (outOfRange)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirectTarget = 32'h0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirectTarget = 32'h0;
        tick();
        tick();
        n_vec++;
        if (pc !== 32'h0) begin
            n_err++; $display("FAIL reset_pc got %h want %h", pc, 32'h0);
        end
        n_vec++;
        if (instrValid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid got %b want 0", instrValid);
        end
        n_vec++;
        if (instr !== NOP) begin
            n_err++; $display("FAIL reset_instr got %h want %h", instr, NOP);
        end
        n_vec++;
        if (instrPc !== 32'h0 || instrPcPlus4 !== 32'h4) begin
            n_err++;
            $display("FAIL reset_ipc got %h/%h want 0/4", instrPc, instrPcPlus4);
        end
        n_vec++;
        if (misaligned !== 1'b0 || outOfRange !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags got %b%b want 00", misaligned, outOfRange);
        end
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (instrValid !== 1'b0 || pc !== 32'h0) begin
            n_err++;
            $display("FAIL idle got v=%b pc=%h want v=0 pc=0", instrValid, pc);
        end
    endtask

    task automatic test_fetch();
        logic [31:0] exp_w [3];
        exp_w[0] = W0;
        exp_w[1] = W1;
        exp_w[2] = W2;
        do_reset();
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (instr !== exp_w[i] || instrValid !== 1'b1) begin
                n_err++;
                $display("FAIL fetch_instr%0d got %h v=%b want %h v=1",
                         i, instr, instrValid, exp_w[i]);
            end
            n_vec++;
            if (instrPc !== 32'(4 * i) || instrPcPlus4 !== 32'(4 * i + 4)) begin
                n_err++;
                $display("FAIL fetch_ipc%0d got %h/%h want %h/%h", i,
                         instrPc, instrPcPlus4, 32'(4 * i), 32'(4 * i + 4));
            end
            n_vec++;
            if (pc !== 32'(4 * i + 4)) begin
                n_err++;
                $display("FAIL fetch_pc%0d got %h want %h", i, pc, 32'(4 * i + 4));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        repeat (3) tick();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++;
            if (instr !== W1 || instrPc !== 32'h4 || instrValid !== 1'b1) begin
                n_err++;
                $display("FAIL stall_hold%0d got %h@%h v=%b want %h@4 v=1",
                         i, instr, instrPc, instrValid, W1);
            end
            n_vec++;
            if (pc !== 32'h8) begin
                n_err++; $display("FAIL stall_pc%0d got %h want 8", i, pc);
            end
        end
        stall = 1'b0;
        tick();
        n_vec++;
        if (instr !== W2 || instrPc !== 32'h8) begin
            n_err++;
            $display("FAIL stall_release got %h@%h want %h@8", instr, instrPc, W2);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        repeat (3) tick();
        redirect = 1'b1;
        redirectTarget = 32'h34;
        stall = 1'b1;
        tick();
        redirect = 1'b0;
        stall = 1'b0;
        n_vec++;
        if (instrValid !== 1'b0 || pc !== 32'h34 || instr !== NOP) begin
            n_err++;
            $display("FAIL redir_bubble got v=%b pc=%h i=%h want v=0 pc=34 i=%h",
                     instrValid, pc, instr, NOP);
        end
        n_vec++;
        if (rom_bus.romAddress !== 5'd13) begin
            n_err++;
            $display("FAIL redir_romaddr got %0d want 13", rom_bus.romAddress);
        end
        tick();
        n_vec++;
        if (instr !== W13 || instrValid !== 1'b1) begin
            n_err++;
            $display("FAIL redir_instr got %h v=%b want %h v=1", instr, instrValid, W13);
        end
        n_vec++;
        if (instrPc !== 32'h34 || instrPcPlus4 !== 32'h38) begin
            n_err++;
            $display("FAIL redir_ipc got %h/%h want 34/38", instrPc, instrPcPlus4);
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        repeat (3) tick();
        redirect = 1'b1;
        redirectTarget = 32'h36;
        tick();
        redirect = 1'b0;
        n_vec++;
        if (misaligned !== 1'b1 || instrValid !== 1'b0 || outOfRange !== 1'b0) begin
            n_err++;
            $display("FAIL mis_enter got m=%b v=%b o=%b want m=1 v=0 o=0",
                     misaligned, instrValid, outOfRange);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++;
            if (pc !== 32'h8 || instrValid !== 1'b0 || misaligned !== 1'b1) begin
                n_err++;
                $display("FAIL mis_frozen%0d got pc=%h v=%b m=%b want pc=8 v=0 m=1",
                         i, pc, instrValid, misaligned);
            end
        end
    endtask

    task automatic test_out_of_range();
        do_reset();
        repeat (2) tick();
        redirect = 1'b1;
        redirectTarget = 32'h80;
        tick();
        redirect = 1'b0;
        n_vec++;
        if (instrValid !== 1'b0 || pc !== 32'h80 || outOfRange !== 1'b0) begin
            n_err++;
            $display("FAIL oor_bubble got v=%b pc=%h o=%b want v=0 pc=80 o=0",
                     instrValid, pc, outOfRange);
        end
        tick();
        n_vec++;
        if (outOfRange !== 1'b1 || instrValid !== 1'b0 || misaligned !== 1'b0) begin
            n_err++;
            $display("FAIL oor_enter got o=%b v=%b m=%b want o=1 v=0 m=0",
                     outOfRange, instrValid, misaligned);
        end
        repeat (2) tick();
        n_vec++;
        if (pc !== 32'h80 || instrPc !== 32'h0 || outOfRange !== 1'b1) begin
            n_err++;
            $display("FAIL oor_frozen got pc=%h ipc=%h o=%b want pc=80 ipc=0 o=1",
                     pc, instrPc, outOfRange);
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (pc !== 32'h0 || outOfRange !== 1'b0 || misaligned !== 1'b0) begin
            n_err++;
            $display("FAIL areset_pc got pc=%h o=%b m=%b want pc=0 o=0 m=0",
                     pc, outOfRange, misaligned);
        end
        n_vec++;
        if (instrValid !== 1'b0 || instr !== NOP || instrPcPlus4 !== 32'h4) begin
            n_err++;
            $display("FAIL areset_ifid got v=%b i=%h p4=%h want v=0 i=%h p4=4",
                     instrValid, instr, instrPcPlus4, NOP);
        end
        #2;
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (instrValid !== 1'b0 || pc !== 32'h0) begin
            n_err++;
            $display("FAIL areset_idle got v=%b pc=%h want v=0 pc=0", instrValid, pc);
        end
        tick();
        n_vec++;
        if (instr !== W0 || instrValid !== 1'b1 || pc !== 32'h4) begin
            n_err++;
            $display("FAIL areset_resume got %h v=%b pc=%h want %h v=1 pc=4",
                     instr, instrValid, pc, W0);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 32'hA000_0000 + 32'(i);
        rom[0]  = W0;
        rom[1]  = W1;
        rom[2]  = W2;
        rom[13] = W13;
        test_reset();
        test_fetch();
        test_stall();
        test_redirect();
        test_misaligned();
        test_out_of_range();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
